// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and load/store share one memory over an IDLE/ACCESS/RESP FSM.
// Define MEM_ARB_RR_EN for round-robin arbitration on ties; the default is fixed priority with load/store winning.
module mem_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_ack,
  output logic [DW-1:0] ls_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       we_q;
  logic       any_req;
  logic       grant_ls;

  assign any_req = if_req | ls_req;

  always_comb begin
`ifdef MEM_ARB_RR_EN
    // On a tie the requester that did not hold the last grant wins.
    grant_ls = (if_req && ls_req) ? ~owner : ls_req;
`else
    grant_ls = ls_req;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    mem_en = 1'b0;
    mem_we = 1'b0;
    if_ack = 1'b0;
    ls_ack = 1'b0;
    case (state)
      ACCESS: begin
        busy   = 1'b1;
        mem_en = 1'b1;
        // The counter still holds its load value only in the first access cycle.
        mem_we = we_q && (cnt == LAT_M1);
      end
      RESP: begin
        busy   = 1'b1;
        if_ack = ~owner;
        ls_ack = owner;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      we_q      <= 1'b0;
      owner     <= 1'b1;
      cnt       <= 4'd0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= grant_ls;
            cnt   <= LAT_M1;
            if (grant_ls) begin
              mem_addr  <= ls_addr;
              mem_wdata <= ls_wdata;
              we_q      <= ls_we;
            end else begin
              mem_addr <= if_addr;
              we_q     <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!we_q) begin
            if (owner) ls_rdata <= mem_rdata;
            else       if_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
